// File: rtl/instruction_decode.sv
// RV64I ID stage: decode, 32x64 register file, immediate build, load-use hazard detect.
// Latency: 1 cycle, input to ID/EX register; the register file read is combinational with a writeback bypass.
// Backpressure: o_stall is raised combinationally on a load-use hazard; a flush overrides the stall and loads a bubble.
module instruction_decode #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic            o_funct7_b5,
  output logic            o_alu_src_imm,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            d_valid, d_alu_src_imm, d_reg_write, d_mem_read;
  logic            d_mem_write, d_branch, d_jump, d_illegal, uses_rs2;

  assign opcode = i_instruction[6:0];
  assign rd     = i_instruction[11:7];
  assign rs1    = i_instruction[19:15];
  assign rs2    = i_instruction[24:20];

  // Register file read with same-cycle writeback bypass; x0 always reads zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = (i_wb_en && i_wb_rd == rs1) ? i_wb_data : regs[rs1];
    if (rs2 != 5'd0) rs2_data = (i_wb_en && i_wb_rd == rs2) ? i_wb_data : regs[rs2];
  end

  // Opcode decode into control bits and the sign-extended immediate
  always_comb begin
    d_valid       = 1'b1;
    d_alu_src_imm = 1'b0;
    d_reg_write   = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_branch      = 1'b0;
    d_jump        = 1'b0;
    d_illegal     = 1'b0;
    uses_rs2      = 1'b0;
    imm           = '0;
    if (i_instruction == 32'h0) begin
      d_valid = 1'b0;
    end else begin
      case (opcode)
        OP_R: begin
          d_reg_write = 1'b1;
          uses_rs2    = 1'b1;
        end
        OP_I: begin
          d_reg_write   = 1'b1;
          d_alu_src_imm = 1'b1;
          imm = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
        end
        OP_LD: begin
          d_reg_write   = 1'b1;
          d_mem_read    = 1'b1;
          d_alu_src_imm = 1'b1;
          imm = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
        end
        OP_ST: begin
          d_mem_write   = 1'b1;
          d_alu_src_imm = 1'b1;
          uses_rs2      = 1'b1;
          imm = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
        end
        OP_BR: begin
          d_branch = 1'b1;
          uses_rs2 = 1'b1;
          imm = {{(XLEN-13){i_instruction[31]}}, i_instruction[31], i_instruction[7],
                 i_instruction[30:25], i_instruction[11:8], 1'b0};
        end
        OP_JAL: begin
          d_jump      = 1'b1;
          d_reg_write = 1'b1;
          imm = {{(XLEN-21){i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                 i_instruction[20], i_instruction[30:21], 1'b0};
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  // Load-use hazard against the load sitting in ID/EX; a flush squashes the request
  always_comb begin
    o_stall = 1'b0;
    if (!i_rst && !i_flush && o_valid && o_mem_read && o_rd != 5'd0 &&
        (rs1 == o_rd || (uses_rs2 && rs2 == o_rd)))
      o_stall = 1'b1;
  end

  // Register file write; x0 writes are dropped and stalls do not block writeback
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_wb_en && i_wb_rd != 5'd0) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  // ID/EX pipeline register: reset, then flush/stall bubble, else the decoded instruction
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || o_stall) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_rs1_data    <= '0;
      o_rs2_data    <= '0;
      o_imm         <= '0;
      o_rs1         <= '0;
      o_rs2         <= '0;
      o_rd          <= '0;
      o_funct3      <= '0;
      o_funct7_b5   <= 1'b0;
      o_alu_src_imm <= 1'b0;
      o_reg_write   <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_branch      <= 1'b0;
      o_jump        <= 1'b0;
      o_illegal     <= 1'b0;
    end else begin
      o_valid       <= d_valid;
      o_pc          <= i_pc;
      o_rs1_data    <= rs1_data;
      o_rs2_data    <= rs2_data;
      o_imm         <= imm;
      o_rs1         <= rs1;
      o_rs2         <= rs2;
      o_rd          <= rd;
      o_funct3      <= i_instruction[14:12];
      o_funct7_b5   <= i_instruction[30];
      o_alu_src_imm <= d_alu_src_imm;
      o_reg_write   <= d_reg_write;
      o_mem_read    <= d_mem_read;
      o_mem_write   <= d_mem_write;
      o_branch      <= d_branch;
      o_jump        <= d_jump;
      o_illegal     <= d_illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: reset, bypass, load-use stall, flush, immediates, x0, illegal.
// Each check samples 1 time unit after the rising edge.
// Stalls are observed combinationally before the edge that consumes them.
module tb_instruction_decode;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_wb_en;
  logic [31:0] i_instruction;
  logic [63:0] i_pc, i_wb_data;
  logic [4:0]  i_wb_rd;
  logic        o_stall, o_valid, o_funct7_b5, o_alu_src_imm, o_reg_write;
  logic        o_mem_read, o_mem_write, o_branch, o_jump, o_illegal;
  logic [63:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_funct3;

  int n_tests = 0;
  int n_fail  = 0;

  // control vector: {valid, reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal}
  logic [7:0] ctl;
  assign ctl = {o_valid, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src_imm, o_illegal};

  localparam logic [31:0] ADD_X3_X5_X6 = {7'd0, 5'd6, 5'd5, 3'd0, 5'd3, 7'b0110011};
  localparam logic [31:0] ADD_X3_X1_X2 = {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
  localparam logic [31:0] ADD_X4_X2_X2 = {7'd0, 5'd2, 5'd2, 3'd0, 5'd4, 7'b0110011};
  localparam logic [31:0] ADD_X6_X5_X0 = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_X3_X0_X0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'b0110011};
  localparam logic [31:0] LD_X5_8_X1   = {12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011};
  localparam logic [31:0] ADDI_X7_X0_5 = {12'd5, 5'd0, 3'b000, 5'd7, 7'b0010011};
  localparam logic [31:0] BEQ_M24      = {1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b0100, 1'b1, 7'b1100011};
  localparam logic [31:0] SD_X3_M8_X4  = {7'b1111111, 5'd3, 5'd4, 3'b011, 5'b11000, 7'b0100011};
  localparam logic [31:0] JAL_X1_M4    = {1'b1, 10'b1111111110, 1'b1, 8'hFF, 5'd1, 7'b1101111};

  instruction_decode dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_pc(i_pc),
    .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_funct3(o_funct3), .o_funct7_b5(o_funct7_b5), .o_alu_src_imm(o_alu_src_imm),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd = 5'd0; i_wb_data = '0;
    i_instruction = ADD_X3_X5_X6; i_pc = 64'h1000;
    step(); step();
    n_tests++;
    if (ctl !== 8'h00 || o_pc !== 64'h0 || o_rd !== 5'd0 || o_imm !== 64'h0 ||
        o_rs1_data !== 64'h0 || o_funct3 !== 3'd0 || o_rs1 !== 5'd0 || o_rs2 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b pc=%h rd=%0d imm=%h, required all zero", ctl, o_pc, o_rd, o_imm);
    end
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b required 0", o_stall);
    end
    i_rst = 1'b0;
    step();
    n_tests++;
    if (o_rs1_data !== 64'h0 || o_rs2_data !== 64'h0 || o_rd !== 5'd3 || ctl !== 8'b1100_0000 ||
        o_pc !== 64'h1000 || o_rs1 !== 5'd5 || o_rs2 !== 5'd6) begin
      n_fail++;
      $display("FAIL first_add: rs1d=%h rs2d=%h rd=%0d ctl=%b pc=%h, required 0 0 3 11000000 1000",
               o_rs1_data, o_rs2_data, o_rd, ctl, o_pc);
    end
  endtask

  task automatic test_bypass();
    i_instruction = ADD_X3_X1_X2; i_pc = 64'h1004;
    i_wb_en = 1'b1; i_wb_rd = 5'd2; i_wb_data = 64'h1234;
    step();
    n_tests++;
    if (o_rs2_data !== 64'h1234 || o_reg_write !== 1'b1 || o_rs1_data !== 64'h0) begin
      n_fail++;
      $display("FAIL wb_bypass: rs2d=%h rw=%b rs1d=%h, required 1234 1 0", o_rs2_data, o_reg_write, o_rs1_data);
    end
    i_wb_rd = 5'd1; i_wb_data = 64'd100;
    i_instruction = ADD_X4_X2_X2; i_pc = 64'h1008;
    step();
    i_wb_en = 1'b0;
    n_tests++;
    if (o_rs1_data !== 64'h1234 || o_rs2_data !== 64'h1234 || o_rd !== 5'd4) begin
      n_fail++;
      $display("FAIL regfile_read: rs1d=%h rs2d=%h rd=%0d, required 1234 1234 4", o_rs1_data, o_rs2_data, o_rd);
    end
  endtask

  task automatic test_load_use();
    i_instruction = LD_X5_8_X1; i_pc = 64'h2000;
    step();
    n_tests++;
    if (ctl !== 8'b1110_0010 || o_rd !== 5'd5 || o_imm !== 64'd8 || o_rs1_data !== 64'd100 || o_funct3 !== 3'b011) begin
      n_fail++;
      $display("FAIL load_decode: ctl=%b rd=%0d imm=%h rs1d=%h, required 11100010 5 8 64", ctl, o_rd, o_imm, o_rs1_data);
    end
    i_instruction = ADD_X6_X5_X0; i_pc = 64'h2004;
    #1;
    n_tests++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b required 1", o_stall);
    end
    step();
    n_tests++;
    if (ctl !== 8'h00 || o_rd !== 5'd0 || o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_bubble: ctl=%b rd=%0d stall=%b, required 0 0 0", ctl, o_rd, o_stall);
    end
    step();
    n_tests++;
    if (o_valid !== 1'b1 || o_rd !== 5'd6 || o_rs1 !== 5'd5 || o_pc !== 64'h2004) begin
      n_fail++;
      $display("FAIL after_stall: valid=%b rd=%0d rs1=%0d pc=%h, required 1 6 5 2004", o_valid, o_rd, o_rs1, o_pc);
    end
  endtask

  task automatic test_flush_and_no_rs2_hazard();
    i_instruction = LD_X5_8_X1; i_pc = 64'h3000;
    step();
    i_instruction = ADD_X6_X5_X0; i_pc = 64'h3004; i_flush = 1'b1;
    #1;
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got %b required 0", o_stall);
    end
    step();
    i_flush = 1'b0;
    n_tests++;
    if (ctl !== 8'h00 || o_rd !== 5'd0 || o_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL flush_bubble: ctl=%b rd=%0d pc=%h, required 0 0 0", ctl, o_rd, o_pc);
    end
    // I-type whose imm[4:0] aliases the load rd must not stall
    i_instruction = LD_X5_8_X1; i_pc = 64'h3008;
    step();
    i_instruction = ADDI_X7_X0_5; i_pc = 64'h300C;
    #1;
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL itype_no_stall: got %b required 0", o_stall);
    end
    step();
    n_tests++;
    if (ctl !== 8'b1100_0010 || o_imm !== 64'd5 || o_rd !== 5'd7) begin
      n_fail++;
      $display("FAIL addi_decode: ctl=%b imm=%h rd=%0d, required 11000010 5 7", ctl, o_imm, o_rd);
    end
  endtask

  task automatic test_immediates();
    i_instruction = BEQ_M24; i_pc = 64'h4000;
    step();
    n_tests++;
    if (ctl !== 8'b1000_1000 || o_imm !== 64'hFFFF_FFFF_FFFF_FFE8) begin
      n_fail++;
      $display("FAIL beq_imm: ctl=%b imm=%h, required 10001000 ffffffffffffffe8", ctl, o_imm);
    end
    i_instruction = SD_X3_M8_X4; i_pc = 64'h4004;
    step();
    n_tests++;
    if (ctl !== 8'b1001_0010 || o_imm !== 64'hFFFF_FFFF_FFFF_FFF8 || o_funct3 !== 3'b011 || o_rs2 !== 5'd3) begin
      n_fail++;
      $display("FAIL sd_imm: ctl=%b imm=%h f3=%0d, required 10010010 fffffffffffffff8 3", ctl, o_imm, o_funct3);
    end
    i_instruction = JAL_X1_M4; i_pc = 64'h4008;
    step();
    n_tests++;
    if (ctl !== 8'b1100_0100 || o_imm !== 64'hFFFF_FFFF_FFFF_FFFC || o_rd !== 5'd1) begin
      n_fail++;
      $display("FAIL jal_imm: ctl=%b imm=%h rd=%0d, required 11000100 fffffffffffffffc 1", ctl, o_imm, o_rd);
    end
  endtask

  task automatic test_x0_illegal_bubble();
    i_instruction = ADD_X3_X0_X0; i_pc = 64'h5000;
    i_wb_en = 1'b1; i_wb_rd = 5'd0; i_wb_data = 64'hDEAD;
    step();
    i_wb_en = 1'b0;
    n_tests++;
    if (o_rs1_data !== 64'h0 || o_rs2_data !== 64'h0) begin
      n_fail++;
      $display("FAIL x0_bypass: rs1d=%h rs2d=%h, required 0 0", o_rs1_data, o_rs2_data);
    end
    step();
    n_tests++;
    if (o_rs1_data !== 64'h0 || o_rs2_data !== 64'h0) begin
      n_fail++;
      $display("FAIL x0_read: rs1d=%h rs2d=%h, required 0 0", o_rs1_data, o_rs2_data);
    end
    i_instruction = 32'hFFFF_FFFF;
    step();
    n_tests++;
    if (ctl !== 8'b1000_0001) begin
      n_fail++;
      $display("FAIL illegal: ctl=%b, required 10000001", ctl);
    end
    i_instruction = 32'h0;
    step();
    n_tests++;
    if (ctl !== 8'h00) begin
      n_fail++;
      $display("FAIL bubble_input: ctl=%b, required 00000000", ctl);
    end
    // reset mid-stream drops the in-flight instruction and clears the register file
    i_instruction = ADD_X4_X2_X2;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    n_tests++;
    if (ctl !== 8'h00) begin
      n_fail++;
      $display("FAIL midstream_reset: ctl=%b, required 0", ctl);
    end
    step();
    n_tests++;
    if (o_valid !== 1'b1 || o_rd !== 5'd4 || o_rs1_data !== 64'h0) begin
      n_fail++;
      $display("FAIL post_reset_decode: valid=%b rd=%0d rs1d=%h, required 1 4 0", o_valid, o_rd, o_rs1_data);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_and_no_rs2_hazard();
    test_immediates();
    test_x0_illegal_bubble();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
